// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle sequencer for the ALU multiply (4'b0001) and divide (4'b0010)
// operations. It runs a WIDTH-iteration unsigned shift-add multiplier and a
// restoring divider behind a start/done handshake. While an operation is in
// flight it stalls the IF/ID/EX pipeline registers, and it drops the stall in
// the cycle the results are valid.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   operation  ALU-control operation code, sampled when start=1
//   start      EX-stage instruction valid
//   flush      synchronous pipeline flush, kills any in-flight operation
//   op_a       multiplicand / dividend
//   op_b       multiplier / divisor
//   busy       high while in RUN or DONE
//   stall      freezes the IF/ID/EX pipeline registers
//   done       one-cycle pulse, results valid in that cycle
//   result_lo  product low half / quotient
//   result_hi  product high half / remainder
//   div_zero   set with done when the divisor was zero
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       operation,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic              is_div;
  // Multiplicand for a multiply, divisor for a divide.
  logic [WIDTH-1:0]  operand;
  // Multiply: {carry, partial product, multiplier}.
  // Divide:   {unused, remainder, quotient}.
  logic [2*WIDTH:0]  acc;

  logic              is_muldiv;
  logic [2*WIDTH:0]  mul_sum;
  logic [2*WIDTH:0]  mul_next;
  logic [WIDTH:0]    div_shifted;
  logic [WIDTH+1:0]  div_trial;
  logic [2*WIDTH:0]  div_next;
  logic [2*WIDTH:0]  acc_next;

  // NOTE: every signal driven here gets a value on every path first, so no
  // latch is inferred even if a branch is added later.
  always_comb begin
    is_muldiv   = (operation == OP_MUL) || (operation == OP_DIV);

    // Shift-add step: the extra top bit catches the carry out of the add.
    mul_sum     = acc;
    if (acc[0]) begin
      mul_sum = acc + {1'b0, operand, {WIDTH{1'b0}}};
    end
    mul_next    = mul_sum >> 1;

    // Restoring step: shift {remainder, quotient} left and trial-subtract.
    div_shifted = acc[2*WIDTH-1:WIDTH-1];
    div_trial   = {1'b0, div_shifted} - {2'b00, operand};
    if (!div_trial[WIDTH+1]) begin
      div_next = {1'b0, div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {1'b0, div_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    acc_next    = is_div ? div_next : mul_next;
  end

  // Combinational so the pipeline freezes in the same cycle start is accepted.
  assign stall = ((state == IDLE) && start && !flush && is_muldiv) ||
                 (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      is_div    <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in this block; the default below is
      // overridden by any later assignment to done in the same cycle.
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && is_muldiv) begin
              div_zero <= 1'b0;
              is_div   <= (operation == OP_DIV);
              busy     <= 1'b1;
              if ((operation == OP_DIV) && (op_b == '0)) begin
                // Divide by zero finishes immediately without iterating.
                state     <= DONE;
                done      <= 1'b1;
                result_lo <= '1;
                result_hi <= op_a;
                div_zero  <= 1'b1;
              end else begin
                state   <= RUN;
                count   <= '0;
                operand <= (operation == OP_DIV) ? op_b : op_a;
                acc     <= {{(WIDTH+1){1'b0}},
                            (operation == OP_DIV) ? op_a : op_b};
              end
            end
          end
          RUN: begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              state     <= DONE;
              done      <= 1'b1;
              result_lo <= acc_next[WIDTH-1:0];
              result_hi <= acc_next[2*WIDTH-1:WIDTH];
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
